// File: rtl/udp_tx.sv
// udp_tx: UDP transmit layer. It buffers the payload in a RAM, optionally checksums it, and streams the header and payload to ip_tx.
// Defining UDP_TX_CHECKSUM_EN enables the pseudo-header checksum; otherwise the checksum field is sent as 16'h0000.
module udp_tx #(
   parameter int RAM_AW = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        udp_send_ram_wdata,
   input  logic [RAM_AW-1:0] udp_send_ram_wr_addr,
   input  logic              udp_send_ram_wr_en,
   input  logic              udp_tx_start,
   input  logic [15:0]       udp_send_data_length,
   input  logic [15:0]       udp_src_port,
   input  logic [15:0]       udp_dst_port,
   input  logic [31:0]       ip_send_source_addr,
   input  logic [31:0]       ip_send_destination_addr,
   input  logic              ip_tx_ack,
   output logic              udp_tx_ready,
   output logic [15:0]       udp_tx_length,
   output logic [7:0]        udp_tx_data,
   output logic              udp_tx_data_valid,
   output logic              udp_tx_end,
   output logic              udp_tx_busy
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CHECK_SUM  = 3'd1,
      CHECK_FOLD = 3'd2,
      WAIT_ACK   = 3'd3,
      SEND_HEAD  = 3'd4,
      SEND_DATA  = 3'd5,
      SEND_END   = 3'd6
   } state_t;

   state_t            state;
   logic [7:0]        mem [0:(1<<RAM_AW)-1];
   logic [7:0]        ram_q;
   logic [RAM_AW-1:0] rd_addr;
   logic [15:0]       len;
   logic [15:0]       src_port;
   logic [15:0]       dst_port;
   logic [15:0]       csum;
   logic [15:0]       cnt;
   logic [15:0]       ulen;

   assign ulen = udp_send_data_length + 16'd8;

`ifdef UDP_TX_CHECKSUM_EN
   logic [31:0] acc;
   logic [7:0]  hi_byte;

   function automatic logic [31:0] pseudo_seed(input logic [31:0] sip, input logic [31:0] dip,
                                               input logic [15:0] sp, input logic [15:0] dp,
                                               input logic [15:0] ul);
      return 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]) +
             32'h0000_0011 + 32'(ul) + 32'(sp) + 32'(dp) + 32'(ul);
   endfunction
`else
   logic unused_ip;
   assign unused_ip = ^{ip_send_source_addr, ip_send_destination_addr};
`endif

   function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [15:0] sp,
                                           input logic [15:0] dp, input logic [15:0] ln,
                                           input logic [15:0] cs);
      case (i)
         3'd0:    return sp[15:8];
         3'd1:    return sp[7:0];
         3'd2:    return dp[15:8];
         3'd3:    return dp[7:0];
         3'd4:    return ln[15:8];
         3'd5:    return ln[7:0];
         3'd6:    return cs[15:8];
         default: return cs[7:0];
      endcase
   endfunction

   // Payload RAM: application write port, one-cycle-latency read port shared by checksum and send.
   always_ff @(posedge clk) begin
      if (udp_send_ram_wr_en) begin
         mem[udp_send_ram_wr_addr] <= udp_send_ram_wdata;
      end
      ram_q <= mem[rd_addr];
   end

   // Main FSM; stream outputs are registered one cycle behind the state that produces them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         udp_tx_ready      <= 1'b0;
         udp_tx_length     <= 16'd0;
         udp_tx_data       <= 8'd0;
         udp_tx_data_valid <= 1'b0;
         udp_tx_end        <= 1'b0;
         udp_tx_busy       <= 1'b0;
         rd_addr           <= '0;
         len               <= 16'd0;
         src_port          <= 16'd0;
         dst_port          <= 16'd0;
         csum              <= 16'd0;
         cnt               <= 16'd0;
`ifdef UDP_TX_CHECKSUM_EN
         acc               <= 32'd0;
         hi_byte           <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               udp_tx_data       <= 8'd0;
               udp_tx_data_valid <= 1'b0;
               udp_tx_end        <= 1'b0;
               if (udp_tx_start) begin
                  len           <= udp_send_data_length;
                  src_port      <= udp_src_port;
                  dst_port      <= udp_dst_port;
                  udp_tx_length <= ulen;
                  udp_tx_busy   <= 1'b1;
                  cnt           <= 16'd0;
                  rd_addr       <= '0;
`ifdef UDP_TX_CHECKSUM_EN
                  acc   <= pseudo_seed(ip_send_source_addr, ip_send_destination_addr,
                                       udp_src_port, udp_dst_port, ulen);
                  state <= CHECK_SUM;
`else
                  csum         <= 16'd0;
                  udp_tx_ready <= 1'b1;
                  state        <= WAIT_ACK;
`endif
               end
            end
`ifdef UDP_TX_CHECKSUM_EN
            CHECK_SUM: begin
               rd_addr <= rd_addr + RAM_AW'(1);
               cnt     <= cnt + 16'd1;
               // ram_q holds payload byte cnt-1 here; odd cnt means an even (high) byte
               if (cnt != 16'd0 && cnt <= len) begin
                  if (cnt[0]) begin
                     if (cnt == len) begin
                        acc <= acc + {16'd0, ram_q, 8'd0};
                     end else begin
                        hi_byte <= ram_q;
                     end
                  end else begin
                     acc <= acc + {16'd0, hi_byte, ram_q};
                  end
               end
               if (cnt == len + 16'd1) begin
                  cnt   <= 16'd0;
                  state <= CHECK_FOLD;
               end
            end
            CHECK_FOLD: begin
               cnt <= cnt + 16'd1;
               if (cnt == 16'd2) begin
                  csum         <= (acc[15:0] == 16'hFFFF) ? 16'hFFFF : ~acc[15:0];
                  udp_tx_ready <= 1'b1;
                  state        <= WAIT_ACK;
               end else begin
                  acc <= 32'(acc[15:0]) + 32'(acc[31:16]);
               end
            end
`endif
            WAIT_ACK: begin
               if (ip_tx_ack) begin
                  udp_tx_ready <= 1'b0;
                  cnt          <= 16'd0;
                  rd_addr      <= '0;
                  state        <= SEND_HEAD;
               end
            end
            SEND_HEAD: begin
               udp_tx_data_valid <= 1'b1;
               udp_tx_data       <= hdr_byte(cnt[2:0], src_port, dst_port, udp_tx_length, csum);
               cnt               <= cnt + 16'd1;
               if (cnt == 16'd7) begin
                  cnt     <= 16'd0;
                  rd_addr <= RAM_AW'(1);
                  if (len == 16'd0) begin
                     udp_tx_end <= 1'b1;
                     state      <= SEND_END;
                  end else begin
                     state <= SEND_DATA;
                  end
               end
            end
            SEND_DATA: begin
               udp_tx_data_valid <= 1'b1;
               udp_tx_data       <= ram_q;
               rd_addr           <= rd_addr + RAM_AW'(1);
               cnt               <= cnt + 16'd1;
               if (cnt == len - 16'd1) begin
                  udp_tx_end <= 1'b1;
                  state      <= SEND_END;
               end
            end
            SEND_END: begin
               udp_tx_data       <= 8'd0;
               udp_tx_data_valid <= 1'b0;
               udp_tx_end        <= 1'b0;
               udp_tx_busy       <= 1'b0;
               state             <= IDLE;
            end
            default: begin
               udp_tx_ready      <= 1'b0;
               udp_tx_data       <= 8'd0;
               udp_tx_data_valid <= 1'b0;
               udp_tx_end        <= 1'b0;
               udp_tx_busy       <= 1'b0;
               state             <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: table-driven and randomized frames for udp_tx, checked against an RFC 768 style byte-list model.
// Expectations follow UDP_TX_CHECKSUM_EN the same way the design does.
module tb_udp_tx;

   localparam int RAM_AW = 11;
`ifdef UDP_TX_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        udp_send_ram_wdata;
   logic [RAM_AW-1:0] udp_send_ram_wr_addr;
   logic              udp_send_ram_wr_en;
   logic              udp_tx_start;
   logic [15:0]       udp_send_data_length;
   logic [15:0]       udp_src_port;
   logic [15:0]       udp_dst_port;
   logic [31:0]       ip_send_source_addr;
   logic [31:0]       ip_send_destination_addr;
   logic              ip_tx_ack;
   logic              udp_tx_ready;
   logic [15:0]       udp_tx_length;
   logic [7:0]        udp_tx_data;
   logic              udp_tx_data_valid;
   logic              udp_tx_end;
   logic              udp_tx_busy;

   int total = 0;
   int bad   = 0;
   logic [7:0] pay [0:2047];

   udp_tx #(.RAM_AW(RAM_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .udp_send_ram_wdata(udp_send_ram_wdata), .udp_send_ram_wr_addr(udp_send_ram_wr_addr),
      .udp_send_ram_wr_en(udp_send_ram_wr_en), .udp_tx_start(udp_tx_start),
      .udp_send_data_length(udp_send_data_length), .udp_src_port(udp_src_port),
      .udp_dst_port(udp_dst_port), .ip_send_source_addr(ip_send_source_addr),
      .ip_send_destination_addr(ip_send_destination_addr), .ip_tx_ack(ip_tx_ack),
      .udp_tx_ready(udp_tx_ready), .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data),
      .udp_tx_data_valid(udp_tx_data_valid), .udp_tx_end(udp_tx_end), .udp_tx_busy(udp_tx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          len;
      logic [31:0] pbytes;
      int          ack_dly;
      logic [15:0] cs_on;
      logic [15:0] exp_ulen;
      bit          poke;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Internet checksum over the pseudo-header, UDP header (checksum field zero) and padded payload.
   function automatic logic [15:0] ref_csum(input int len, input logic [31:0] sip, input logic [31:0] dip,
                                            input logic [15:0] sp, input logic [15:0] dp);
      logic [7:0]  b[$];
      logic [15:0] ul;
      longint      s;
      logic [15:0] c;
      ul = 16'(len + 8);
      b = {sip[31:24], sip[23:16], sip[15:8], sip[7:0], dip[31:24], dip[23:16], dip[15:8], dip[7:0],
           8'h00, 8'h11, ul[15:8], ul[7:0],
           sp[15:8], sp[7:0], dp[15:8], dp[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
      for (int i = 0; i < len; i++) b.push_back(pay[i]);
      if (b.size() % 2 == 1) b.push_back(8'h00);
      s = 0;
      for (int i = 0; i < b.size(); i += 2) s += longint'({b[i], b[i+1]});
      while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
      c = ~s[15:0];
      if (c == 16'h0000) c = 16'hFFFF;
      return c;
   endfunction

   task automatic idle_quiet(input string nm, input int n);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (udp_tx_ready || udp_tx_data_valid || udp_tx_end || udp_tx_busy || udp_tx_data != 8'd0) ok = 1'b0;
         step();
      end
      check(nm, 64'(ok), 64'd1);
   endtask

   task automatic run_frame(input string nm, input int len, input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp, input int ack_dly,
                            input logic [15:0] cs, input logic [15:0] exp_ulen, input bit poke);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      int n, ends, endpos, exp_lat;
      bit ok;
      for (int i = 0; i < len; i++) begin
         udp_send_ram_wr_en   = 1'b1;
         udp_send_ram_wr_addr = RAM_AW'(i);
         udp_send_ram_wdata   = pay[i];
         step();
      end
      udp_send_ram_wr_en       = 1'b0;
      ip_send_source_addr      = sip;
      ip_send_destination_addr = dip;
      udp_src_port             = sp;
      udp_dst_port             = dp;
      udp_send_data_length     = 16'(len);
      udp_tx_start             = 1'b1;
      step();
      udp_tx_start = 1'b0;
      exp_lat = CSUM_ON ? len + 6 : 1;
      n = 1;
      while (!udp_tx_ready && n < 3000) begin
         step();
         n++;
      end
      check({nm, " start_to_ready"}, 64'(n), 64'(exp_lat));
      check({nm, " tx_length"}, 64'(udp_tx_length), 64'(exp_ulen));
      if (ack_dly > 0) begin
         ok = 1'b1;
         for (int i = 0; i < ack_dly; i++) begin
            if (!udp_tx_ready || udp_tx_data_valid) ok = 1'b0;
            step();
         end
         check({nm, " ack_stall"}, 64'(ok), 64'd1);
      end
      ip_tx_ack = 1'b1;
      step();
      ip_tx_ack = 1'b0;
      check({nm, " ready_drop"}, 64'({udp_tx_ready, udp_tx_data_valid}), 64'd0);
      step();
      exp_q = {sp[15:8], sp[7:0], dp[15:8], dp[7:0], exp_ulen[15:8], exp_ulen[7:0], cs[15:8], cs[7:0]};
      for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
      n = 0;
      ends = 0;
      endpos = -1;
      while (udp_tx_data_valid && n < 2000) begin
         got_q.push_back(udp_tx_data);
         if (udp_tx_end) begin
            ends++;
            endpos = n;
         end
         n++;
         udp_tx_start = poke && (n == 10);
         step();
      end
      udp_tx_start = 1'b0;
      check({nm, " byte_count"}, 64'(got_q.size()), 64'(len + 8));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s byte%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
      check({nm, " end_count"}, 64'(ends), 64'd1);
      check({nm, " end_pos"}, 64'(endpos), 64'(len + 7));
      check({nm, " after_frame"}, 64'({udp_tx_data_valid, udp_tx_data, udp_tx_end, udp_tx_busy}), 64'd0);
      if (poke) idle_quiet({nm, " no_second_frame"}, len + 30);
   endtask

   initial begin
      vec_t vecs[6];
      logic [31:0] sip, dip, p;
      logic [15:0] sp, dp, cs;
      int len, n, k;
      bit seen_end;

      vecs[0] = '{len: 4, pbytes: 32'h01020304, ack_dly: 0,  cs_on: 16'h3952, exp_ulen: 16'd12, poke: 1'b0};
      vecs[1] = '{len: 3, pbytes: 32'h01020300, ack_dly: 50, cs_on: 16'h3958, exp_ulen: 16'd11, poke: 1'b0};
      vecs[2] = '{len: 0, pbytes: 32'h00000000, ack_dly: 3,  cs_on: 16'h3D60, exp_ulen: 16'd8,  poke: 1'b0};
      vecs[3] = '{len: 1, pbytes: 32'hAB000000, ack_dly: 1,  cs_on: 16'h925D, exp_ulen: 16'd9,  poke: 1'b0};
      vecs[4] = '{len: 2, pbytes: 32'h3D5C0000, ack_dly: 2,  cs_on: 16'hFFFF, exp_ulen: 16'd10, poke: 1'b0};
      vecs[5] = '{len: 4, pbytes: 32'h01020304, ack_dly: 0,  cs_on: 16'h3952, exp_ulen: 16'd12, poke: 1'b1};

      rst_n = 1'b0;
      udp_send_ram_wdata = 8'd0;
      udp_send_ram_wr_addr = '0;
      udp_send_ram_wr_en = 1'b0;
      udp_tx_start = 1'b0;
      udp_send_data_length = 16'd0;
      udp_src_port = 16'd0;
      udp_dst_port = 16'd0;
      ip_send_source_addr = 32'd0;
      ip_send_destination_addr = 32'd0;
      ip_tx_ack = 1'b0;
      step();
      step();
      check("reset_outputs", 64'({udp_tx_ready, udp_tx_length, udp_tx_data, udp_tx_data_valid,
                                  udp_tx_end, udp_tx_busy}), 64'd0);
      rst_n = 1'b1;
      step();

      for (int v = 0; v < 6; v++) begin
         p = vecs[v].pbytes;
         for (int i = 0; i < 4; i++) pay[i] = p[31-8*i -: 8];
         run_frame($sformatf("vec%0d", v), vecs[v].len, 32'hC0A8010A, 32'hC0A80103, 16'h1F90, 16'h1F90,
                   vecs[v].ack_dly, CSUM_ON ? vecs[v].cs_on : 16'h0000, vecs[v].exp_ulen, vecs[v].poke);
      end

      // stray ack while idle must not start anything
      ip_tx_ack = 1'b1;
      step();
      ip_tx_ack = 1'b0;
      idle_quiet("stray_ack", 20);

      // reset in the middle of the payload
      for (int i = 0; i < 8; i++) begin
         pay[i] = 8'($urandom);
         udp_send_ram_wr_en = 1'b1;
         udp_send_ram_wr_addr = RAM_AW'(i);
         udp_send_ram_wdata = pay[i];
         step();
      end
      udp_send_ram_wr_en = 1'b0;
      udp_send_data_length = 16'd8;
      udp_tx_start = 1'b1;
      step();
      udp_tx_start = 1'b0;
      n = 1;
      while (!udp_tx_ready && n < 3000) begin
         step();
         n++;
      end
      check("rst_mid ready", 64'(udp_tx_ready), 64'd1);
      ip_tx_ack = 1'b1;
      step();
      ip_tx_ack = 1'b0;
      k = 0;
      n = 0;
      while (k < 11 && n < 50) begin
         step();
         n++;
         if (udp_tx_data_valid) k++;
      end
      check("rst_mid in_data", 64'(k), 64'd11);
      rst_n = 1'b0;
      #1;
      check("rst_mid outputs", 64'({udp_tx_ready, udp_tx_length, udp_tx_data, udp_tx_data_valid,
                                    udp_tx_end, udp_tx_busy}), 64'd0);
      seen_end = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (udp_tx_end || udp_tx_data_valid) seen_end = 1'b1;
      end
      check("rst_mid no_end", 64'(seen_end), 64'd0);
      rst_n = 1'b1;
      step();
      cs = CSUM_ON ? ref_csum(8, 32'hC0A8010A, 32'hC0A80103, 16'h1F90, 16'h1F90) : 16'h0000;
      run_frame("after_rst", 8, 32'hC0A8010A, 32'hC0A80103, 16'h1F90, 16'h1F90, 1, cs, 16'd16, 1'b0);

      // randomized frames, last one at the maximum payload length
      for (int r = 0; r < 13; r++) begin
         len = (r == 12) ? 1472 : int'($urandom_range(0, 40));
         sip = $urandom;
         dip = $urandom;
         sp  = 16'($urandom);
         dp  = 16'($urandom);
         for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
         cs = CSUM_ON ? ref_csum(len, sip, dip, sp, dp) : 16'h0000;
         run_frame($sformatf("rand%0d", r), len, sip, dip, sp, dp, int'($urandom_range(0, 4)), cs,
                   16'(len + 8), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
